// File: rtl/config_field_editor_pkg.sv
// Shared encodings and default limits for the configuration field editor.
// Field 0 sits at the LSBs of every packed per-field vector.
package config_field_editor_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_HORA   = 2'd1,
        MODE_FECHA  = 2'd2,
        MODE_TIMER  = 2'd3
    } mode_e;

    localparam int F_SS    = 0;
    localparam int F_MM    = 1;
    localparam int F_HH    = 2;
    localparam int F_YEAR  = 3;
    localparam int F_MES   = 4;
    localparam int F_DAY   = 5;
    localparam int F_WDAY  = 6;
    localparam int F_SS_T  = 7;
    localparam int F_MM_T  = 8;
    localparam int F_HH_T  = 9;

    // Listed from field 9 down to field 0.
    localparam logic [69:0] DEF_LIMIT_MIN = {7'd0, 7'd0, 7'd0, 7'd1, 7'd1,
                                             7'd1, 7'd0, 7'd0, 7'd0, 7'd0};
    localparam logic [69:0] DEF_LIMIT_MAX = {7'd23, 7'd59, 7'd59, 7'd7, 7'd31,
                                             7'd12, 7'd99, 7'd23, 7'd59, 7'd59};

endpackage

// File: rtl/config_field_editor_button_repeat_tick.sv
// Rising-edge tick plus hold-then-repeat ticks for one debounced button.
// The edge register tracks the level during reset so a held button never fires.
module button_repeat_tick #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    input  logic inhibit_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    logic             prev_q;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             edge_w;

    assign edge_w = level_i & ~prev_q;

    // Down-counter: reaching zero while armed emits a tick and reloads the repeat period.
    always_comb begin
        tick_o  = 1'b0;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        if (inhibit_i || !level_i) begin
            armed_d = 1'b0;
            cnt_d   = '0;
        end else if (edge_w) begin
            tick_o  = 1'b1;
            armed_d = 1'b1;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else if (armed_q) begin
            if (cnt_q == '0) begin
                tick_o = 1'b1;
                cnt_d  = CNT_W'(REPEAT_CYCLES - 1);
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        prev_q <= level_i;
        if (reset) begin
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/config_field_editor.sv
// Bank of bounded edit fields with per-mode cursor, UP/DOWN auto-repeat editing
// and a clamped load port for write-back from the running clock.
import config_field_editor_pkg::*;

module config_field_editor #(
    parameter int                      N_FIELDS      = 10,
    parameter int                      W             = 7,
    parameter int                      IDX_W         = 4,
    parameter int                      CURSOR_W      = 2,
    parameter int                      G1            = 3,
    parameter int                      G2            = 4,
    parameter int                      G3            = 3,
    parameter logic [N_FIELDS*W-1:0]   LIMIT_MIN     = DEF_LIMIT_MIN,
    parameter logic [N_FIELDS*W-1:0]   LIMIT_MAX     = DEF_LIMIT_MAX,
    parameter int                      HOLD_CYCLES   = 50_000_000,
    parameter int                      REPEAT_CYCLES = 10_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enUP,
    input  logic                    enDOWN,
    input  logic                    enLEFT,
    input  logic                    enRIGHT,
    input  logic [1:0]              config_mode,
    input  logic                    load_en,
    input  logic [IDX_W-1:0]        load_idx,
    input  logic [W-1:0]            load_value,
    output logic [N_FIELDS*W-1:0]   field_values,
    output logic [CURSOR_W-1:0]     cursor_location,
    output logic [IDX_W-1:0]        sel_field,
    output logic [3:0]              sel_digit1,
    output logic [3:0]              sel_digit0,
    output logic                    edit_tick
);

    function automatic logic [7:0] to_bcd(input logic [W-1:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = '0;
        units = v[3:0];
        for (int k = 1; k < 10; k++) begin
            if (v >= W'(k * 10)) begin
                tens  = 4'(k);
                units = 4'(v - W'(k * 10));
            end
        end
        return {tens, units};
    endfunction

    mode_e                mode;
    logic [W-1:0]         vals_q [N_FIELDS];
    logic [W-1:0]         vals_d [N_FIELDS];
    logic [W-1:0]         lim_min [N_FIELDS];
    logic [W-1:0]         lim_max [N_FIELDS];
    logic [CURSOR_W-1:0]  cursor_q, cursor_d;
    logic [CURSOR_W:0]    grp_size;
    logic [1:0]           mode_q;
    logic                 left_prev_q, right_prev_q;
    logic                 left_tick, right_tick;
    logic                 up_tick, dn_tick, both_held;
    logic                 edit_act;
    logic                 edit_tick_q;
    logic [W-1:0]         sel_val;
    logic [7:0]           sel_bcd;

    assign mode = mode_e'(config_mode);

    for (genvar g = 0; g < N_FIELDS; g++) begin : g_fields
        assign lim_min[g]               = LIMIT_MIN[g*W +: W];
        assign lim_max[g]               = LIMIT_MAX[g*W +: W];
        assign field_values[g*W +: W]   = vals_q[g];
    end

    assign both_held = enUP & enDOWN;

    button_repeat_tick #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_up (
        .clk(clk), .reset(reset), .level_i(enUP), .inhibit_i(both_held), .tick_o(up_tick)
    );

    button_repeat_tick #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dn (
        .clk(clk), .reset(reset), .level_i(enDOWN), .inhibit_i(both_held), .tick_o(dn_tick)
    );

    assign left_tick  = enLEFT  & ~left_prev_q;
    assign right_tick = enRIGHT & ~right_prev_q;

    always_comb begin
        grp_size  = (CURSOR_W+1)'(1);
        sel_field = '0;
        case (mode)
            MODE_HORA: begin
                grp_size  = (CURSOR_W+1)'(G1);
                sel_field = IDX_W'(cursor_q);
            end
            MODE_FECHA: begin
                grp_size  = (CURSOR_W+1)'(G2);
                sel_field = IDX_W'(G1) + IDX_W'(cursor_q);
            end
            MODE_TIMER: begin
                grp_size  = (CURSOR_W+1)'(G3);
                sel_field = IDX_W'(G1 + G2) + IDX_W'(cursor_q);
            end
            default: ;
        endcase
    end

    always_comb begin
        cursor_d = cursor_q;
        if (mode == MODE_NORMAL || config_mode != mode_q) begin
            cursor_d = '0;
        end else if (left_tick && !right_tick) begin
            cursor_d = ({1'b0, cursor_q} == grp_size - 1'b1) ? '0 : cursor_q + 1'b1;
        end else if (right_tick && !left_tick) begin
            cursor_d = (cursor_q == '0) ? CURSOR_W'(grp_size - 1'b1) : cursor_q - 1'b1;
        end
    end

    assign edit_act = (mode != MODE_NORMAL) && (up_tick || dn_tick)
                      && (sel_field < IDX_W'(N_FIELDS));

    // A user edit on the same field takes priority over a concurrent load.
    always_comb begin
        for (int i = 0; i < N_FIELDS; i++) begin
            vals_d[i] = vals_q[i];
            if (edit_act && sel_field == IDX_W'(i)) begin
                if (up_tick)
                    vals_d[i] = (vals_q[i] == lim_max[i]) ? lim_min[i] : vals_q[i] + 1'b1;
                else
                    vals_d[i] = (vals_q[i] == lim_min[i]) ? lim_max[i] : vals_q[i] - 1'b1;
            end else if (load_en && load_idx == IDX_W'(i)) begin
                if (load_value < lim_min[i])
                    vals_d[i] = lim_min[i];
                else if (load_value > lim_max[i])
                    vals_d[i] = lim_max[i];
                else
                    vals_d[i] = load_value;
            end
        end
    end

    always_ff @(posedge clk) begin
        left_prev_q  <= enLEFT;
        right_prev_q <= enRIGHT;
        mode_q       <= config_mode;
        if (reset) begin
            for (int i = 0; i < N_FIELDS; i++) vals_q[i] <= lim_min[i];
            cursor_q    <= '0;
            edit_tick_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_FIELDS; i++) vals_q[i] <= vals_d[i];
            cursor_q    <= cursor_d;
            edit_tick_q <= edit_act;
        end
    end

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < N_FIELDS; i++)
            if (sel_field == IDX_W'(i)) sel_val = vals_q[i];
    end

    assign sel_bcd         = to_bcd(sel_val);
    assign sel_digit1      = sel_bcd[7:4];
    assign sel_digit0      = sel_bcd[3:0];
    assign cursor_location = cursor_q;
    assign edit_tick       = edit_tick_q;

endmodule

// File: tb/tb_config_field_editor.sv
// Directed bench for config_field_editor with a cycle-level reference model
// (press-age arithmetic, modular cursor) checked every cycle plus literal spot checks.
module tb_config_field_editor;

    localparam int NF   = 10;
    localparam int HOLD = 8;
    localparam int REP  = 3;

    logic        clk = 1'b0;
    logic        reset, enUP, enDOWN, enLEFT, enRIGHT;
    logic [1:0]  config_mode;
    logic        load_en;
    logic [3:0]  load_idx;
    logic [6:0]  load_value;
    logic [69:0] field_values;
    logic [1:0]  cursor_location;
    logic [3:0]  sel_field;
    logic [3:0]  sel_digit1, sel_digit0;
    logic        edit_tick;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    config_field_editor #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
        .clk(clk), .reset(reset), .enUP(enUP), .enDOWN(enDOWN), .enLEFT(enLEFT),
        .enRIGHT(enRIGHT), .config_mode(config_mode), .load_en(load_en),
        .load_idx(load_idx), .load_value(load_value), .field_values(field_values),
        .cursor_location(cursor_location), .sel_field(sel_field),
        .sel_digit1(sel_digit1), .sel_digit0(sel_digit0), .edit_tick(edit_tick)
    );

    always #5 clk = ~clk;

    int MINV [NF] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    int MAXV [NF] = '{59, 59, 23, 99, 12, 31, 7, 59, 59, 23};
    int BASE [4]  = '{0, 0, 3, 7};
    int GSZ  [4]  = '{1, 3, 4, 3};

    // Reference model state
    int m_val [NF];
    int m_cur;
    int m_pmode;
    bit m_et;
    bit pU, pD, pL, pR;
    bit up_arm, dn_arm;
    int up_age, dn_age;

    task automatic check(input string nm, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int fld(input int i);
        return int'(field_values[i*7 +: 7]);
    endfunction

    always @(posedge clk) begin : model
        int sel, g;
        bit ue, de, le, re, ut, dt, ed;
        if (reset) begin
            for (int i = 0; i < NF; i++) m_val[i] <= MINV[i];
            m_cur   <= 0;
            m_et    <= 1'b0;
            up_arm  <= 1'b0;
            dn_arm  <= 1'b0;
            up_age  <= 0;
            dn_age  <= 0;
        end else begin
            ue = enUP && !pU;
            de = enDOWN && !pD;
            le = enLEFT && !pL;
            re = enRIGHT && !pR;
            ut = 1'b0;
            dt = 1'b0;
            if ((enUP && enDOWN) || !enUP) up_arm <= 1'b0;
            else if (ue) begin ut = 1'b1; up_arm <= 1'b1; up_age <= 1; end
            else if (up_arm) begin
                if (up_age >= HOLD && (up_age - HOLD) % REP == 0) ut = 1'b1;
                up_age <= up_age + 1;
            end
            if ((enUP && enDOWN) || !enDOWN) dn_arm <= 1'b0;
            else if (de) begin dt = 1'b1; dn_arm <= 1'b1; dn_age <= 1; end
            else if (dn_arm) begin
                if (dn_age >= HOLD && (dn_age - HOLD) % REP == 0) dt = 1'b1;
                dn_age <= dn_age + 1;
            end
            sel = (config_mode == 0) ? 0 : BASE[config_mode] + m_cur;
            ed  = (config_mode != 0) && (ut || dt) && sel < NF;
            for (int i = 0; i < NF; i++) begin
                if (ed && i == sel) begin
                    if (ut) m_val[i] <= (m_val[i] == MAXV[i]) ? MINV[i] : m_val[i] + 1;
                    else    m_val[i] <= (m_val[i] == MINV[i]) ? MAXV[i] : m_val[i] - 1;
                end else if (load_en && int'(load_idx) == i) begin
                    m_val[i] <= (int'(load_value) < MINV[i]) ? MINV[i] :
                                (int'(load_value) > MAXV[i]) ? MAXV[i] : int'(load_value);
                end
            end
            g = GSZ[config_mode];
            if (config_mode == 0 || int'(config_mode) != m_pmode) m_cur <= 0;
            else if (le && !re) m_cur <= (m_cur + 1) % g;
            else if (re && !le) m_cur <= (m_cur + g - 1) % g;
            m_et <= ed;
        end
        pU <= enUP; pD <= enDOWN; pL <= enLEFT; pR <= enRIGHT;
        m_pmode <= int'(config_mode);
    end

    always @(negedge clk) begin : compare
        logic [69:0] ef;
        int es, sv;
        if (chk_en) begin
            for (int i = 0; i < NF; i++) ef[i*7 +: 7] = 7'(m_val[i]);
            es = (config_mode == 0) ? 0 : BASE[config_mode] + m_cur;
            sv = (es < NF) ? m_val[es] : 0;
            check("field_values", field_values, ef);
            check("cursor_location", 70'(cursor_location), 70'(m_cur));
            check("sel_field", 70'(sel_field), 70'(es));
            check("sel_digit1", 70'(sel_digit1), 70'(sv / 10));
            check("sel_digit0", 70'(sel_digit0), 70'(sv % 10));
            check("edit_tick", 70'(edit_tick), 70'(m_et));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_left();
        enLEFT = 1'b1; cyc(1); enLEFT = 1'b0; cyc(1);
    endtask

    initial begin
        reset = 1'b1; enUP = 1'b0; enDOWN = 1'b0; enLEFT = 1'b0; enRIGHT = 1'b0;
        config_mode = 2'd0; load_en = 1'b0; load_idx = '0; load_value = '0;
        cyc(1);
        chk_en = 1'b1;
        cyc(1);
        reset = 1'b0;

        // Reset values seen through the date group
        config_mode = 2'd2; cyc(1);
        check("lit_year", 70'(fld(3)), 70'd0);
        check("lit_mes", 70'(fld(4)), 70'd1);
        check("lit_day", 70'(fld(5)), 70'd1);
        check("lit_wday", 70'(fld(6)), 70'd1);
        check("lit_sel_date", 70'(sel_field), 70'd3);

        // SS wrap at MAX and back at MIN
        config_mode = 2'd1; cyc(1);
        load_en = 1'b1; load_idx = 4'd0; load_value = 7'd59; cyc(1);
        load_en = 1'b0;
        check("lit_ss_load", 70'(fld(0)), 70'd59);
        enUP = 1'b1; cyc(1);
        check("lit_ss_up_wrap", 70'(fld(0)), 70'd0);
        check("lit_etick_hi", 70'(edit_tick), 70'd1);
        enUP = 1'b0; cyc(1);
        check("lit_etick_lo", 70'(edit_tick), 70'd0);
        enDOWN = 1'b1; cyc(1);
        check("lit_ss_dn_wrap", 70'(fld(0)), 70'd59);
        enDOWN = 1'b0; cyc(1);

        // Cursor wrapping and mode-change reset
        config_mode = 2'd2; cyc(1);
        enRIGHT = 1'b1; cyc(1);
        check("lit_cur_right_wrap", 70'(cursor_location), 70'd3);
        check("lit_sel_wday", 70'(sel_field), 70'd6);
        enRIGHT = 1'b0; cyc(1);
        pulse_left();
        check("lit_cur_left_wrap", 70'(cursor_location), 70'd0);
        config_mode = 2'd1; cyc(1);
        pulse_left(); pulse_left();
        check("lit_cur_hh", 70'(cursor_location), 70'd2);
        pulse_left();
        check("lit_cur_wrap_g1", 70'(cursor_location), 70'd0);
        pulse_left();
        config_mode = 2'd3; cyc(1);
        check("lit_cur_mode3", 70'(cursor_location), 70'd0);
        check("lit_sel_mode3", 70'(sel_field), 70'd7);

        // Auto-repeat on MM
        config_mode = 2'd1; cyc(1);
        pulse_left();
        enUP = 1'b1; cyc(1);
        check("lit_mm_edge", 70'(fld(1)), 70'd1);
        cyc(8);
        check("lit_mm_hold", 70'(fld(1)), 70'd2);
        cyc(12);
        check("lit_mm_repeat", 70'(fld(1)), 70'd6);
        enDOWN = 1'b1; cyc(10);
        check("lit_mm_both", 70'(fld(1)), 70'd6);
        enUP = 1'b0; enDOWN = 1'b0; cyc(1);

        // Load clamping and out-of-range index
        config_mode = 2'd2; cyc(1);
        load_en = 1'b1; load_idx = 4'd5; load_value = 7'd45; cyc(1);
        check("lit_day_clamp", 70'(fld(5)), 70'd31);
        load_idx = 4'd12; load_value = 7'd5; cyc(1);
        check("lit_idx12_mes", 70'(fld(4)), 70'd1);
        check("lit_idx12_day", 70'(fld(5)), 70'd31);
        load_idx = 4'd4; load_value = 7'd0; cyc(1);
        check("lit_mes_clamp_lo", 70'(fld(4)), 70'd1);
        load_en = 1'b0; cyc(1);
        pulse_left(); pulse_left();
        check("lit_digit1_day", 70'(sel_digit1), 70'd3);
        check("lit_digit0_day", 70'(sel_digit0), 70'd1);

        // Edit beats a same-cycle load on HH
        config_mode = 2'd1; cyc(1);
        pulse_left(); pulse_left();
        enUP = 1'b1; load_en = 1'b1; load_idx = 4'd2; load_value = 7'd10; cyc(1);
        check("lit_hh_edit_wins", 70'(fld(2)), 70'd1);
        load_en = 1'b0; enUP = 1'b0; cyc(1);

        // Reset while UP is held
        enUP = 1'b1; cyc(5);
        reset = 1'b1; cyc(1);
        check("lit_rst_hh", 70'(fld(2)), 70'd0);
        check("lit_rst_day", 70'(fld(5)), 70'd1);
        reset = 1'b0; cyc(15);
        check("lit_held_no_tick_ss", 70'(fld(0)), 70'd0);
        check("lit_held_no_tick_et", 70'(edit_tick), 70'd0);
        enUP = 1'b0; cyc(1);
        enUP = 1'b1; cyc(1);
        check("lit_repress_ss", 70'(fld(0)), 70'd1);
        enUP = 1'b0; cyc(2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_field_editor.md
Name: config_field_editor

Overview:
- Parametrised successor to the fixed hour/date/timer configuration counters.
- Holds N_FIELDS bounded edit values (time, date, weekday, timer) in one register bank, each with its own MIN/MAX wrap limits.
- A per-mode horizontal cursor selects the field; UP/DOWN buttons edit it, with auto-repeat while held.
- Adds a load port so the running clock/RTC can write values back. Sits between the debounced buttons and the display/RTC write path.

Parameters:
- N_FIELDS, 10, total editable fields
- W, 7, value width; every MAX must be ≤ 99
- IDX_W, 4, field index width
- CURSOR_W, 2, cursor width; each group size ≤ 2^CURSOR_W
- G1, 3, fields in mode 1 (hour: SS,MM,HH = idx 0..2)
- G2, 4, fields in mode 2 (date: YEAR,MES,DAY,weekday = idx 3..6)
- G3, 3, fields in mode 3 (timer: SS_T,MM_T,HH_T = idx 7..9)
- LIMIT_MIN, packed N_FIELDS*W, per-field minimum, field 0 at LSBs; default 0,0,0,0,1,1,1,0,0,0
- LIMIT_MAX, packed N_FIELDS*W, per-field maximum; default 59,59,23,99,12,31,7,59,59,23
- HOLD_CYCLES, 50_000_000, held cycles before auto-repeat starts
- REPEAT_CYCLES, 10_000_000, period between repeat ticks

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enUP  in  1  debounced level
- enDOWN  in  1  debounced level
- enLEFT  in  1  debounced level
- enRIGHT  in  1  debounced level
- config_mode  in  2  0 normal, 1 hour, 2 date, 3 timer
- load_en  in  1  write strobe
- load_idx  in  IDX_W  target field
- load_value  in  W  value to write
- field_values  out  N_FIELDS*W  all field registers, field 0 at LSBs
- cursor_location  out  CURSOR_W  cursor inside current group
- sel_field  out  IDX_W  base(mode) + cursor
- sel_digit1  out  4  BCD tens of selected field
- sel_digit0  out  4  BCD units of selected field
- edit_tick  out  1  one-cycle pulse, same cycle a user edit becomes visible

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset.
- Reset: each field = its LIMIT_MIN; cursor_location = 0; edit_tick = 0; repeat counters = 0.
  - During reset, edge registers load the current button levels, so a button held through reset gives no tick.
- Edge ticks: tick = level & ~previous level, for all four buttons.
- UP/DOWN repeat (one instance each):
  - Rising edge gives one tick.
  - If still held HOLD_CYCLES cycles after the edge, one tick, then one tick every REPEAT_CYCLES.
  - Release clears the counter.
  - UP and DOWN both high: no ticks, both counters cleared.
- Cursor:
  - Group size G = G1/G2/G3 for modes 1/2/3.
  - LEFT tick increments, RIGHT tick decrements, wrapping within 0..G-1 (cursor at G-1 plus LEFT → 0; cursor at 0 plus RIGHT → G-1).
  - LEFT and RIGHT ticks in the same cycle: no move.
  - Mode 0: cursor forced to 0, moves ignored.
  - Any change of config_mode: cursor = 0 on the next edge.
- sel_field:
  - Base offsets: mode 1 → 0, mode 2 → G1, mode 3 → G1+G2.
  - sel_field = base + cursor; 0 in mode 0.
- Edit (config_mode ≠ 0 only), applied to the field given by the registered sel_field:
  - UP tick: value == MAX → MIN, else value + 1.
  - DOWN tick: value == MIN → MAX, else value − 1.
  - Result is registered: visible one cycle after the tick, with edit_tick high in that same cycle.
  - Cursor move and edit in the same cycle: the edit hits the pre-move field.
- Load (any mode):
  - Writes clamp(load_value, MIN, MAX) to field load_idx.
  - load_idx ≥ N_FIELDS: ignored.
  - Same cycle as a user edit to the same field: the edit wins and the load is dropped. Loads to other fields proceed.
  - A load never asserts edit_tick.
- BCD: sel_digit1/sel_digit0 = tens/units of the selected field, combinational from registered state.
- Reset mid-hold: repeat restarts only after release and a new press.

Decomposition:
- Shared package holds:
  - mode encodings (MODE_NORMAL=0, MODE_HORA=1, MODE_FECHA=2, MODE_TIMER=3)
  - field index constants (F_SS … F_HH_T)
  - default LIMIT_MIN/LIMIT_MAX vectors
- One sub-module, button_repeat_tick: edge detect plus hold/repeat counter, parametrised by HOLD_CYCLES/REPEAT_CYCLES; instantiated for UP and DOWN.
- LEFT/RIGHT use plain edge detect in the top level.

Test Plan (HOLD_CYCLES=8, REPEAT_CYCLES=3):
- Reset, then mode 2 → day and month read 1, weekday 1, year 0. Cursor 0 → sel_field 3.
- Mode 1, field SS = 59, UP pulse → SS = 0, edit_tick one cycle. DOWN pulse → 59.
- Mode 2, cursor 0: RIGHT → cursor 3 (weekday); LEFT → 0. Mode 1, cursor 2: LEFT → 0. Switch to mode 3 → cursor 0, sel_field 7.
- Mode 1, hold UP for 20 cycles from MM = 0 → ticks at edge, +8, +11, +14, +17, +20 cycles after the edge → MM = 6. Raise DOWN as well → no further change.
- load_idx 5 with 45 → DAY = 31 (clamped). load_idx 12 → no change. Load to HH in the same cycle as an UP edit of HH → edit result kept.
- Assert reset while UP has been held 5 cycles and keep UP held → all fields at MIN, no tick until UP is released and pressed again.
